// File: rtl/packer_pkg.sv
// Shared types and sizing for the 96-bit operand packer.
package packer_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned N_WORDS = 6;
    localparam int unsigned FRAME_W = WORD_W * N_WORDS;
    localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/packer_out_slot.sv
// One-entry valid/ready output register holding a packed frame.
module packer_out_slot
    import packer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  frame_t data_i,
    input  logic   ready_i,
    output logic   valid_o,
    output frame_t data_o,
    output logic   free_o
);

    logic   valid_q, valid_d;
    frame_t data_q, data_d;

    assign free_o  = !valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Load takes priority so a simultaneous consume and refill keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/operand_packer_96.sv
// Packs six 16-bit operands into a 96-bit frame; optional frame counter
// enabled by `define OPERAND_PACKER_CNT_EN.
module operand_packer_96
    import packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_sof,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [FRAME_W-1:0] m_data,
    output logic               err_resync,
    output logic [15:0]        frame_cnt
);

    pack_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    frame_t           buf_q, buf_d;
    logic             err_q, err_d;

    logic             word_acc;
    logic             resync;
    logic [CNT_W-1:0] wr_idx;
    logic             slot_free;
    logic             load;
    frame_t           load_data;

    assign s_ready  = (state_q == FILL);
    assign word_acc = s_valid & s_ready;
    assign resync   = word_acc & s_sof & (cnt_q != '0);
    // A start-of-frame word always lands in the x1 slot, discarding any partial frame.
    assign wr_idx   = s_sof ? '0 : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_data = buf_q;
        case (state_q)
            FILL: begin
                if (word_acc) begin
                    err_d = resync;
                    for (int unsigned i = 0; i < N_WORDS; i++) begin
                        if (32'(wr_idx) == i) begin
                            buf_d[WORD_W*(N_WORDS-i)-1 -: WORD_W] = s_data;
                        end
                    end
                    load_data = buf_d;
                    if (wr_idx == CNT_W'(N_WORDS - 1)) begin
                        if (slot_free) begin
                            load  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = FULL;
                            cnt_d   = CNT_W'(N_WORDS);
                        end
                    end else begin
                        cnt_d = wr_idx + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign err_resync = err_q;

    packer_out_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (load_data),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .free_o  (slot_free)
    );

`ifdef OPERAND_PACKER_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (m_valid & m_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_packer_96.sv
// Self-checking bench for operand_packer_96 against a queue-based frame model.
module tb_operand_packer_96;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [95:0] m_data;
    logic        err_resync;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    operand_packer_96 dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .err_resync (err_resync),
        .frame_cnt  (frame_cnt)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [15:0] part[$];
    logic [95:0] exp_q[$];
    logic        exp_err = 1'b0;
    logic [15:0] exp_cnt = '0;
    int unsigned err_seen = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pack_frame();
        logic [95:0] f = '0;
        foreach (part[k]) f = {f[79:0], part[k]};
        return f;
    endfunction

    function automatic logic [15:0] exp_frame_cnt();
`ifdef OPERAND_PACKER_CNT_EN
        return exp_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic cycle(output logic accepted);
        logic w, f, sof;
        logic [15:0] d;
        @(negedge clk);
        w   = s_valid && s_ready;
        f   = m_valid && m_ready;
        sof = s_sof;
        d   = s_data;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (f && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
        end
        if (w) begin
            if (sof && part.size() != 0) begin
                part.delete();
                exp_err = 1'b1;
            end
            part.push_back(d);
            if (part.size() == 6) begin
                exp_q.push_back(pack_frame());
                part.delete();
            end
        end
        if (err_resync === 1'b1) err_seen++;
        check("m_valid", m_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
        check("s_ready", s_ready, exp_q.size() < 2);
        check("err_resync", err_resync, exp_err);
        check("frame_cnt", frame_cnt, exp_frame_cnt());
        accepted = w;
    endtask

    task automatic idle(input int unsigned n);
        logic a;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) cycle(a);
    endtask

    task automatic send(input logic [15:0] word, input logic sof);
        logic a = 1'b0;
        int unsigned tries = 0;
        s_valid = 1'b1;
        s_data  = word;
        s_sof   = sof;
        while (!a && tries < 50) begin
            cycle(a);
            tries++;
        end
        if (!a) check("send_timeout", 1'b0, 1'b1);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        part.delete();
        exp_q.delete();
        exp_cnt = '0;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 96'h0);
        check("rst_err", err_resync, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0);
        check("rst_s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic a;
        int unsigned e0;

        #2;
        do_reset();

        // 1: single frame, latency of one edge
        m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) send(16'(i), i == 1);
        check("t1_valid", m_valid, 1'b1);
        check("t1_frame", m_data, 96'h0001_0002_0003_0004_0005_0006);
        idle(1);
        check("t1_drained", m_valid, 1'b0);

        // 2: 12 words back-to-back
        for (int i = 0; i < 12; i++) send(16'(16'h0100 + i), 1'b0);
        idle(2);

        // 3: backpressure fills slot and buffer
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'(16'h0200 + i), 1'b0);
        check("t3_full", s_ready, 1'b0);
        check("t3_first", m_data, 96'h0200_0201_0202_0203_0204_0205);
        idle(3);
        m_ready = 1'b1;
        idle(1);
        check("t3_second", m_data, 96'h0206_0207_0208_0209_020a_020b);
        check("t3_ready_back", s_ready, 1'b1);
        idle(2);

        // 4: resync on s_sof mid-frame
        e0 = err_seen;
        send(16'h000a, 1'b0);
        send(16'h000b, 1'b0);
        send(16'h000c, 1'b0);
        send(16'h0001, 1'b1);
        for (int i = 2; i <= 6; i++) send(16'(i), 1'b0);
        check("t4_frame", m_data, 96'h0001_0002_0003_0004_0005_0006);
        idle(2);
        check("t4_err_pulses", 32'(err_seen - e0), 32'd1);

        // 5: reset mid-frame
        for (int i = 0; i < 3; i++) send(16'(16'h0300 + i), 1'b0);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(16'(16'h0400 + i), 1'b0);
        check("t5_frame", m_data, 96'h0400_0401_0402_0403_0404_0405);
        idle(1);

        // 6: frame counter after three frames
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 18; i++) send(16'(i * 7), 1'b0);
        idle(2);
`ifdef OPERAND_PACKER_CNT_EN
        check("t6_frame_cnt", frame_cnt, 16'd3);
`else
        check("t6_frame_cnt", frame_cnt, 16'd0);
`endif

        // Randomized traffic with occasional resyncs and backpressure
        for (int n = 0; n < 3000; n++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_sof   = ($urandom_range(0, 15) == 0);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            cycle(a);
        end
        m_ready = 1'b1;
        idle(4);
        check("final_drained", m_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
